fifo_level: RTL and testbench
=============================

// Module: fifo_level
// PURPOSE
//  Parametrised synchronous FIFO: single clock, show-ahead read, full DWIDTH data path.
//  Adds occupancy count, programmable almost-full/almost-empty, sticky overflow/underflow, sync flush.
//  Sits between peripheral datapaths (UART RX/TX, SPI, DMA staging) and the Cortex-M3 AHB/APB slave logic.
//  Status signals drive interrupts and flow control.
// PARAMETERS
//  DWIDTH    8              data word width in bits (>=1)
//  AWIDTH    4              address width; DEPTH = 2**AWIDTH entries (>=1)
//  AF_LEVEL  2**AWIDTH-2    almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2              almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1         clock, all logic on rising edge
//  reset_n       in   1         synchronous reset, active low
//  flush         in   1         synchronous flush, active high
//  clr_err       in   1         clears overflow/underflow, active high
//  wr            in   1         write request
//  w_data        in   DWIDTH    write data
//  rd            in   1         read (pop) request
//  r_data        out  DWIDTH    head-of-queue data (show-ahead)
//  empty         out  1         FIFO holds 0 entries
//  full          out  1         FIFO holds DEPTH entries
//  almost_empty  out  1         count <= AE_LEVEL
//  almost_full   out  1         count >= AF_LEVEL
//  count         out  AWIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1         sticky: write attempted while full and not accepted
//  underflow     out  1         sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): w_ptr=r_ptr=0, count=0, empty=1, full=0.
//    almost_empty=1, almost_full=0, overflow=underflow=0. Storage array not reset.
//  - Priority per edge: reset_n > flush > rd/wr.
//  - Flush: pointers, count, empty/full/almost_* take reset values.
//    overflow/underflow keep their values; rd/wr that cycle are ignored and flag nothing.
//  - Write accept: wr_acc = wr & ~full. Read accept: rd_acc = rd & ~empty.
//    Both evaluated on the flags registered at the start of the cycle.
//  - wr_acc: mem[w_ptr] <= w_data; w_ptr <= w_ptr+1, wrapping DEPTH-1 -> 0.
//  - rd_acc: r_ptr <= r_ptr+1, wrapping DEPTH-1 -> 0.
//  - r_data = mem[r_ptr], combinational. Valid only when empty=0; X/stale when empty.
//    Popped word is visible before the rd edge; the next word is visible the cycle after.
//  - count_next = count + wr_acc - rd_acc. Arithmetic is AWIDTH+1 bits; never exceeds DEPTH or goes below 0.
//  - Flags are registered from count_next, so they are valid in the cycle after the causing edge:
//    empty=(count_next==0), full=(count_next==DEPTH), almost_empty=(count_next<=AE_LEVEL),
//    almost_full=(count_next>=AF_LEVEL).
//  - Simultaneous rd & wr:
//    - 0<count<DEPTH: both accepted, count unchanged, flags unchanged.
//    - empty: write only, no underflow, count=1. Written word is not readable the same cycle.
//    - full: read only; write dropped, overflow set, count=DEPTH-1.
//  - overflow <= 1 on (wr & full); underflow <= 1 on (rd & empty); both hold until clr_err or reset.
//    clr_err and a new error in the same cycle: flag is set (set wins).
//  - No combinational path from wr/rd to any output. r_data depends only on registered r_ptr and the array.
// TESTING
//  1. Reset, write 0x00..0x0F (16 writes, AWIDTH=4): count 0->16; almost_full rises after the 14th write.
//     full rises after the 16th; empty falls after the 1st.
//  2. FIFO full, wr=1 w_data=0xAA -> overflow=1, count stays 16.
//     Then read 16: r_data sequence 0x00..0x0F, 0xAA never appears, empty=1 after the last pop.
//  3. FIFO empty, rd=1 -> underflow=1, count stays 0. Pulse clr_err -> underflow=0 next cycle.
//  4. Hold count=5, assert rd&wr for 40 cycles (pointer wrap twice) -> count stays 5.
//     Data out in exact write order.
//  5. FIFO at 9 entries with overflow=1, pulse flush with wr=1 -> count=0, empty=1, overflow still 1, no write.
//  6. Mid-fill (count=7), drive reset_n=0 one edge -> all outputs at reset values next cycle.
//     First write afterwards reads back correctly.

Source files
------------

// File: rtl/fifo_level.sv
// Single-clock show-ahead FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module fifo_level #(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned AWIDTH   = 4,
    parameter int unsigned AF_LEVEL = (2 ** AWIDTH) - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              clr_err,
    input  logic              wr,
    input  logic [DWIDTH-1:0] w_data,
    input  logic              rd,
    output logic [DWIDTH-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    localparam logic [AWIDTH:0] DepthC = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] AfLvl  = (AWIDTH + 1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AeLvl  = (AWIDTH + 1)'(AE_LEVEL);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [AWIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ae_q, ae_d;
    logic              af_q, af_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic wr_acc;
    logic rd_acc;

    // Accepts use the flags registered at the start of the cycle, never the incoming request.
    assign wr_acc = wr & ~full_q;
    assign rd_acc = rd & ~empty_q;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            if (wr_acc) begin
                w_ptr_d = w_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                r_ptr_d = r_ptr_q + 1'b1;
            end
            count_d = count_q + {{AWIDTH{1'b0}}, wr_acc} - {{AWIDTH{1'b0}}, rd_acc};
            if (clr_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            // A new error in the same cycle as clr_err wins.
            if (wr & full_q) begin
                ovf_d = 1'b1;
            end
            if (rd & empty_q) begin
                unf_d = 1'b1;
            end
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DepthC);
        ae_d    = (count_d <= AeLvl);
        af_d    = (count_d >= AfLvl);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && wr_acc) begin
            mem_q[w_ptr_q] <= w_data;
        end
    end

    assign r_data       = mem_q[r_ptr_q];
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_level.sv
// Randomised and directed bench for fifo_level, checked against a queue-based reference model.
module tb_fifo_level;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned AE    = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          rd = 1'b0;
    logic [DW-1:0] r_data;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    bit            seen_aa;

    always #5 clk = ~clk;

    fifo_level #(
        .DWIDTH  (DW),
        .AWIDTH  (AW),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .clr_err     (clr_err),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = model_q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
        if (n > 0) begin
            check("r_data", 32'(r_data), 32'(model_q[0]));
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, then compare.
    task automatic step(input logic rn, input logic fl, input logic ce, input logic w,
                        input logic r, input logic [DW-1:0] d);
        bit was_full, was_empty;
        reset_n = rn;
        flush   = fl;
        clr_err = ce;
        wr      = w;
        rd      = r;
        w_data  = d;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        @(posedge clk);
        #1;
        if (!rn) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (fl) begin
            model_q.delete();
        end else begin
            if (ce) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (w && was_full) m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) void'(model_q.pop_front());
            if (w && !was_full) model_q.push_back(d);
        end
        check_model();
    endtask

    task automatic wr1(input logic [DW-1:0] d);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic rd1();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr1(8'(i));
            if (i == 0) check("empty_falls", 32'(empty), 32'd0);
            if (i == 12) check("af_low_13", 32'(almost_full), 32'd0);
            if (i == 13) check("af_rise_14", 32'(almost_full), 32'd1);
            if (i == 14) check("full_low_15", 32'(full), 32'd0);
        end
        check("full_16", 32'(full), 32'd1);

        // Overflow on full, then drain in order
        wr1(8'hAA);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        seen_aa = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 32'(r_data), 32'(i));
            if (r_data == 8'hAA) seen_aa = 1'b1;
            rd1();
        end
        check("no_aa", 32'(seen_aa), 32'd0);
        check("drained_empty", 32'(empty), 32'd1);

        // Underflow and clear
        rd1();
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("unf_clr", 32'(underflow), 32'd0);
        check("ovf_clr", 32'(overflow), 32'd0);

        // Clear and new error together: set wins
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("unf_set_wins", 32'(underflow), 32'd1);

        // Simultaneous rd/wr on empty: write only
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5C);
        check("rw_empty_cnt", 32'(count), 32'd1);

        // Hold count=5 with rd&wr for 40 cycles
        for (int i = 0; i < 4; i++) wr1(8'($urandom));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
        check("hold5", 32'(count), 32'd5);

        // Full with rd&wr: read only, overflow flagged
        for (int i = 0; i < 11; i++) wr1(8'($urandom));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        check("rw_full_cnt", 32'(count), 32'd15);
        check("rw_full_ovf", 32'(overflow), 32'd1);

        // Nine entries with overflow set, flush with wr=1
        for (int i = 0; i < 6; i++) rd1();
        check("at9", 32'(count), 32'd9);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
        check("flush_cnt", 32'(count), 32'd0);
        check("flush_ovf", 32'(overflow), 32'd1);
        check("flush_empty", 32'(empty), 32'd1);

        // Reset mid-fill
        for (int i = 0; i < 7; i++) wr1(8'($urandom));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
        check("midrst_cnt", 32'(count), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        wr1(8'hC3);
        check("post_rst_data", 32'(r_data), 32'hC3);

        // Randomised phases biased toward filling, draining and mixed traffic
        for (int ph = 0; ph < 24; ph++) begin
            int wp, rp;
            wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
            rp = 100 - wp;
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) < wp),
                     ($urandom_range(0, 99) < rp), 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
